// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
// Module   : regfile_param
// Brief    : Multi-read integer register file with write bypass, hardwired x0,
//            reset-driven init sweep and per-register pending-write scoreboard.
// Revision : 1.0
// ============================================================================
module regfile_param #(
   parameter int XLEN      = 32,
   parameter int DEPTH     = 32,
   parameter int AW        = $clog2(DEPTH),
   parameter int NUM_RD    = 2,
   parameter int INIT_MODE = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_RD*AW-1:0]   raddr,
   output logic [NUM_RD*XLEN-1:0] rdata,
   output logic [NUM_RD-1:0]      rbusy,
   input  logic                   we,
   input  logic [AW-1:0]          waddr,
   input  logic [XLEN-1:0]        wdata,
   input  logic                   sb_set,
   input  logic [AW-1:0]          sb_addr,
   output logic                   init_busy
);

   typedef enum logic [0:0] {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t            state_q;
   logic [AW-1:0]     cnt_q;
   logic [XLEN-1:0]   regs_q [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic [XLEN-1:0]   init_val;
   logic              run_we;

   assign init_busy = (state_q == S_INIT);
   assign init_val  = (INIT_MODE == 1) ? XLEN'(cnt_q) : '0;
   assign run_we    = (state_q == S_RUN) && we && (waddr != '0);

   // The sweep exits after writing DEPTH-1, so cnt never needs to wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
      end else if (state_q == S_INIT) begin
         cnt_q <= cnt_q + AW'(1);
         if (cnt_q == AW'(DEPTH - 1)) begin
            state_q <= S_RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == S_INIT) begin
            regs_q[cnt_q] <= init_val;
         end else if (run_we) begin
            regs_q[waddr] <= wdata;
         end
      end
   end

   // Set is applied after clear so a same-cycle new producer keeps the bit.
   always_comb begin
      busy_d = busy_q;
      if (state_q == S_RUN) begin
         if (we) begin
            busy_d[waddr] = 1'b0;
         end
         if (sb_set) begin
            busy_d[sb_addr] = 1'b1;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0] ra;
      logic          hit;

      assign ra  = raddr[k*AW +: AW];
      assign hit = we && (waddr == ra);

      assign rdata[k*XLEN +: XLEN] = (init_busy || (ra == '0)) ? '0 :
                                     hit                       ? wdata :
                                                                 regs_q[ra];
      assign rbusy[k] = init_busy | (busy_q[ra] & ~hit);
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_param
// Brief    : Directed and random checks of regfile_param in two configurations.
// Revision : 1.0
// ============================================================================
module tb_regfile_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Configuration A: 32x32, two read ports, init loads index
   logic        rst_a;
   logic [9:0]  raddr_a;
   logic [63:0] rdata_a;
   logic [1:0]  rbusy_a;
   logic        we_a;
   logic [4:0]  waddr_a;
   logic [31:0] wdata_a;
   logic        sb_set_a;
   logic [4:0]  sb_addr_a;
   logic        init_busy_a;

   // Configuration B: 16x64, three read ports, init loads zero
   logic         rst_b;
   logic [11:0]  raddr_b;
   logic [191:0] rdata_b;
   logic [2:0]   rbusy_b;
   logic         we_b;
   logic [3:0]   waddr_b;
   logic [63:0]  wdata_b;
   logic         sb_set_b;
   logic [3:0]   sb_addr_b;
   logic         init_busy_b;

   regfile_param #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .INIT_MODE(1)) u_dut_a (
      .clk(clk), .rst(rst_a), .raddr(raddr_a), .rdata(rdata_a), .rbusy(rbusy_a),
      .we(we_a), .waddr(waddr_a), .wdata(wdata_a), .sb_set(sb_set_a),
      .sb_addr(sb_addr_a), .init_busy(init_busy_a)
   );

   regfile_param #(.XLEN(64), .DEPTH(16), .NUM_RD(3), .INIT_MODE(0)) u_dut_b (
      .clk(clk), .rst(rst_b), .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b),
      .we(we_b), .waddr(waddr_b), .wdata(wdata_b), .sb_set(sb_set_b),
      .sb_addr(sb_addr_b), .init_busy(init_busy_b)
   );

   logic [31:0] mem_a  [32];
   logic        pend_a [32];
   logic [63:0] mem_b  [16];
   logic        pend_b [16];
   int          total = 0;
   int          bad   = 0;
   int          cycles;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] pick_a();
      if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
      return 5'($urandom_range(0, 31));
   endfunction

   // Reference behaviour: x0 reads zero, a same-cycle write is forwarded.
   function automatic logic [31:0] exp_rd_a(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (we_a && waddr_a == a) return wdata_a;
      return mem_a[a];
   endfunction

   function automatic logic exp_busy_a(input logic [4:0] a);
      return pend_a[a] && !(we_a && waddr_a == a);
   endfunction

   function automatic logic [63:0] exp_rd_b(input logic [3:0] a);
      if (a == 4'd0) return 64'd0;
      if (we_b && waddr_b == a) return wdata_b;
      return mem_b[a];
   endfunction

   function automatic logic exp_busy_b(input logic [3:0] a);
      return pend_b[a] && !(we_b && waddr_b == a);
   endfunction

   task automatic commit_a();
      if (we_a && waddr_a != 5'd0) mem_a[waddr_a] = wdata_a;
      if (we_a) pend_a[waddr_a] = 1'b0;
      if (sb_set_a) pend_a[sb_addr_a] = 1'b1;
      pend_a[0] = 1'b0;
   endtask

   task automatic commit_b();
      if (we_b && waddr_b != 4'd0) mem_b[waddr_b] = wdata_b;
      if (we_b) pend_b[waddr_b] = 1'b0;
      if (sb_set_b) pend_b[sb_addr_b] = 1'b1;
      pend_b[0] = 1'b0;
   endtask

   task automatic count_init_a();
      cycles = 0;
      while (init_busy_a && cycles < 100) begin
         we_a      = 1'b1;
         waddr_a   = 5'($urandom);
         wdata_a   = $urandom;
         sb_set_a  = 1'b1;
         sb_addr_a = 5'($urandom);
         raddr_a   = 10'($urandom);
         #1;
         check("a_sweep_rdata", rdata_a, 64'd0);
         check("a_sweep_rbusy", rbusy_a, 64'(2'b11));
         cycles++;
         tick();
      end
      we_a     = 1'b0;
      sb_set_a = 1'b0;
      check("a_init_cycles", cycles, 64'd32);
      for (int i = 0; i < 32; i++) begin
         mem_a[i]  = 32'(i);
         pend_a[i] = 1'b0;
      end
   endtask

   initial begin
      rst_a = 1'b1; raddr_a = '0; we_a = 1'b0; waddr_a = '0; wdata_a = '0;
      sb_set_a = 1'b0; sb_addr_a = '0;
      rst_b = 1'b1; raddr_b = '0; we_b = 1'b0; waddr_b = '0; wdata_b = '0;
      sb_set_b = 1'b0; sb_addr_b = '0;
      tick();
      tick();

      raddr_a = {5'd31, 5'd5};
      raddr_b = {4'd3, 4'd2, 4'd1};
      #1;
      check("a_rst_init_busy", init_busy_a, 64'd1);
      check("a_rst_rbusy", rbusy_a, 64'(2'b11));
      check("a_rst_rdata", rdata_a, 64'd0);
      check("b_rst_init_busy", init_busy_b, 64'd1);
      check("b_rst_rbusy", rbusy_b, 64'(3'b111));

      // Init sweep on A, with write and scoreboard traffic that must be ignored
      rst_a = 1'b0;
      count_init_a();

      for (int i = 0; i < 32; i++) begin
         raddr_a = {5'(31 - i), 5'(i)};
         #1;
         check("a_init_val_p0", rdata_a[31:0], 64'(i));
         check("a_init_val_p1", rdata_a[63:32], 64'(31 - i));
         check("a_init_rbusy", rbusy_a, 64'd0);
         tick();
      end
      raddr_a = {5'd31, 5'd5};
      #1;
      check("a_reg5", rdata_a[31:0], 64'h5);
      check("a_reg31", rdata_a[63:32], 64'h1F);
      tick();

      // x0 protection
      we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hDEADBEEF;
      sb_set_a = 1'b1; sb_addr_a = 5'd0; raddr_a = {5'd0, 5'd0};
      #1;
      check("a_x0_wcycle", rdata_a, 64'd0);
      check("a_x0_rbusy_w", rbusy_a, 64'd0);
      tick(); commit_a();
      we_a = 1'b0; sb_set_a = 1'b0;
      #1;
      check("a_x0_after", rdata_a, 64'd0);
      check("a_x0_rbusy_after", rbusy_a, 64'd0);
      tick();

      // Bypass on both ports
      we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'hA5A5A5A5; raddr_a = {5'd7, 5'd7};
      #1;
      check("a_byp_p0", rdata_a[31:0], 64'hA5A5A5A5);
      check("a_byp_p1", rdata_a[63:32], 64'hA5A5A5A5);
      tick(); commit_a();
      we_a = 1'b0;
      #1;
      check("a_byp_next_p0", rdata_a[31:0], 64'hA5A5A5A5);
      check("a_byp_next_p1", rdata_a[63:32], 64'hA5A5A5A5);
      tick();

      // Scoreboard on x9
      raddr_a = {5'd0, 5'd9}; sb_set_a = 1'b1; sb_addr_a = 5'd9;
      #1;
      check("a_sb_set_cycle", rbusy_a[0], 64'd0);
      tick(); commit_a();
      sb_set_a = 1'b0;
      #1;
      check("a_sb_next", rbusy_a[0], 64'd1);
      tick();
      we_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'h12345678;
      #1;
      check("a_sb_bypass_busy", rbusy_a[0], 64'd0);
      check("a_sb_bypass_data", rdata_a[31:0], 64'h12345678);
      tick(); commit_a();
      we_a = 1'b0;
      #1;
      check("a_sb_cleared", rbusy_a[0], 64'd0);
      check("a_sb_data", rdata_a[31:0], 64'h12345678);
      tick();
      sb_set_a = 1'b1; sb_addr_a = 5'd9; we_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'h0BADF00D;
      #1;
      tick(); commit_a();
      sb_set_a = 1'b0; we_a = 1'b0;
      #1;
      check("a_sb_set_wins", rbusy_a[0], 64'd1);
      check("a_sb_set_wins_data", rdata_a[31:0], 64'h0BADF00D);
      tick();

      // Random traffic on A
      for (int n = 0; n < 200; n++) begin
         we_a = 1'($urandom_range(0, 1)); waddr_a = pick_a(); wdata_a = $urandom;
         sb_set_a = 1'($urandom_range(0, 1)); sb_addr_a = pick_a();
         raddr_a = {pick_a(), pick_a()};
         #1;
         for (int k = 0; k < 2; k++) begin
            check("a_rand_rdata", rdata_a[k*32 +: 32], exp_rd_a(raddr_a[k*5 +: 5]));
            check("a_rand_rbusy", rbusy_a[k], exp_busy_a(raddr_a[k*5 +: 5]));
         end
         tick(); commit_a();
      end

      // Reset in the middle of a sweep
      we_a = 1'b0; sb_set_a = 1'b1; sb_addr_a = 5'd12;
      tick(); commit_a();
      sb_set_a = 1'b0; raddr_a = {5'd0, 5'd12};
      #1;
      check("a_pre_rst_busy", rbusy_a[0], 64'd1);
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      for (int n = 0; n < 10; n++) begin
         #1;
         check("a_part_sweep_busy", init_busy_a, 64'd1);
         tick();
      end
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      count_init_a();
      raddr_a = {5'd7, 5'd12};
      #1;
      check("a_rst_sb_cleared", rbusy_a[0], 64'd0);
      check("a_resweep_reg12", rdata_a[31:0], 64'd12);
      check("a_resweep_reg7", rdata_a[63:32], 64'd7);
      tick();

      // Configuration B: init length, zero init, random traffic on three ports
      rst_b = 1'b0;
      cycles = 0;
      while (init_busy_b && cycles < 100) begin
         cycles++;
         tick();
      end
      check("b_init_cycles", cycles, 64'd16);
      for (int i = 0; i < 16; i++) begin
         mem_b[i]  = 64'd0;
         pend_b[i] = 1'b0;
      end
      for (int i = 0; i < 16; i++) begin
         raddr_b = {4'(i + 11), 4'(i + 5), 4'(i)};
         #1;
         check("b_init_zero", rdata_b, 192'd0 == rdata_b ? rdata_b[63:0] : 64'hFFFF_FFFF_FFFF_FFFF);
         check("b_init_rbusy", rbusy_b, 64'd0);
         tick();
      end
      for (int n = 0; n < 300; n++) begin
         we_b = 1'($urandom_range(0, 1)); waddr_b = 4'($urandom_range(0, 15));
         wdata_b = {$urandom, $urandom};
         sb_set_b = 1'($urandom_range(0, 1)); sb_addr_b = 4'($urandom_range(0, 15));
         raddr_b = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
         #1;
         for (int k = 0; k < 3; k++) begin
            check("b_rand_rdata", rdata_b[k*64 +: 64], exp_rd_b(raddr_b[k*4 +: 4]));
            check("b_rand_rbusy", rbusy_b[k], exp_busy_b(raddr_b[k*4 +: 4]));
         end
         tick(); commit_b();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
